turn_signal_cond: RTL

//  Upstream conditioner for the tail-light sequencer (carFSM).
//  - Synchronizes and debounces the raw lever/hazard switches.
//  - Resolves conflicting requests.
//  - Drives clean left/right requests plus a blink-rate tick into the sequencer.
//  - Runs in the single system clock domain.

---
 rtl/turn_signal_cond.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/turn_signal_cond.sv
`timescale 1ns/1ps
// turn_signal_cond: synchronizes and debounces lever/hazard switches, arbitrates requests, and divides a blink tick.
// Optional TURN_COND_LATCH_EN: the hazard switch acts as a push-button toggle instead of a level.
module turn_signal_cond #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lever_l_raw,
  input  logic       lever_r_raw,
  input  logic       hazard_raw,
  output logic       left,
  output logic       right,
  output logic       tick,
  output logic [1:0] mode
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    HAZARD = 2'b11
  } state_t;

  logic [2:0] raw_vec;
  logic [2:0] deb_vec;
  logic       dl, dr, hz;

  assign raw_vec = {hazard_raw, lever_r_raw, lever_l_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic          meta_reg;
      logic          sync_reg;
      logic          deb_reg;
      logic [CW-1:0] cnt_reg;

      // A change is accepted only after DEB_CYCLES consecutive differing synced samples.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          deb_reg  <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= raw_vec[gi];
          sync_reg <= meta_reg;
          if (sync_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            deb_reg <= sync_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign deb_vec[gi] = deb_reg;
    end
  endgenerate

  assign dl = deb_vec[0];
  assign dr = deb_vec[1];

`ifdef TURN_COND_LATCH_EN
  logic hz_latch_reg;
  logic hz_rise;

  // Toggle on the same edge the debounced hazard rises, so latency matches the level mode.
  assign hz_rise = g_deb[2].sync_reg & ~deb_vec[2] & (g_deb[2].cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hz_latch_reg <= 1'b0;
    end else begin
      hz_latch_reg <= hz_latch_reg ^ hz_rise;
    end
  end

  assign hz = hz_latch_reg;
`else
  assign hz = deb_vec[2];
`endif

  state_t        state_reg, state_next;
  logic [TW-1:0] div_reg;
  logic          tick_reg;
  logic          div_clear;

  always_comb begin
    state_next = state_reg;
    if (hz) begin
      state_next = HAZARD;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dl && !dr)      state_next = LEFT;
          else if (dr && !dl) state_next = RIGHT;
        end
        LEFT:    if (!dl || dr) state_next = IDLE;
        RIGHT:   if (!dr || dl) state_next = IDLE;
        HAZARD:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Restarting the divider on every state change fixes the first tick at TICK_DIV cycles after entry.
  assign div_clear = (state_next == IDLE) || (state_next != state_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (div_clear) begin
        div_reg  <= '0;
        tick_reg <= 1'b0;
      end else begin
        tick_reg <= (div_reg == DIV_LAST);
        div_reg  <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      end
    end
  end

  assign left  = (state_reg == LEFT)  || (state_reg == HAZARD);
  assign right = (state_reg == RIGHT) || (state_reg == HAZARD);
  assign mode  = state_reg;
  assign tick  = tick_reg;

endmodule
